// File: rtl/iq_fifo_pkg.sv
// I/Q sample FIFO shared definitions.
// Default sample geometry and pointer-width helper.
package iq_fifo_pkg;

  localparam int IQ_DATA_W = 24;
  localparam int IQ_NCH    = 2;

  typedef logic [IQ_NCH-1:0][IQ_DATA_W-1:0] iq_samp_t;

  // Pointer width: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/iq_fifo_ctrl.sv
// I/Q sample FIFO control: pointers, accept logic,
// occupancy, threshold flags and sticky error flags.
module iq_fifo_ctrl
  import iq_fifo_pkg::*;
#(
  parameter  int DEPTH     = 8,
  parameter  int AFULL_TH  = DEPTH - 1,
  parameter  int AEMPTY_TH = 1,
  localparam int AW        = $clog2(DEPTH),
  localparam int PW        = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_in,
  input  logic          pull_out,
  input  logic          clr_err,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] wr_idx,
  output logic [AW-1:0] rd_idx,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [PW-1:0] level,
  output logic          overflow,
  output logic          underflow
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("iq_fifo_ctrl: DEPTH must be a power of two >= 2");
  end

  localparam logic [PW-1:0] AF_LVL = PW'(AFULL_TH);
  localparam logic [PW-1:0] AE_LVL = PW'(AEMPTY_TH);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          ovf_set;
  logic          udf_set;

  assign wr_idx = wptr[AW-1:0];
  assign rd_idx = rptr[AW-1:0];

  // Status comes only from registered pointers.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0])
              && (wptr[AW] != rptr[AW]);
  assign level = wptr - rptr;

  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

  // A pull frees a slot in the same edge, so a full
  // FIFO still takes a push when paired with a pull.
  assign wr_en = push_in && (!full || pull_out);
  assign rd_en = pull_out && !empty;

  assign ovf_set = push_in && !wr_en;
  assign udf_set = pull_out && empty;

  // Pointer advance on accepted operations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PW'(1);
      if (rd_en) rptr <= rptr + PW'(1);
    end
  end

  // Sticky errors; a new error beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (udf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

endmodule

// File: rtl/iq_sample_fifo.sv
// I/Q sample FIFO top: storage array and head
// output gating around the control block.
module iq_sample_fifo
  import iq_fifo_pkg::*;
#(
  parameter  int DATA_W    = IQ_DATA_W,
  parameter  int NCH       = IQ_NCH,
  parameter  int DEPTH     = 8,
  parameter  int AFULL_TH  = DEPTH - 1,
  parameter  int AEMPTY_TH = 1,
  localparam int SW        = NCH * DATA_W,
  localparam int AW        = $clog2(DEPTH),
  localparam int PW        = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_in,
  input  logic [SW-1:0] samp_in,
  input  logic          pull_out,
  input  logic          clr_err,
  output logic [SW-1:0] samp_out,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [PW-1:0] level,
  output logic          overflow,
  output logic          underflow
);

  logic          wr_en;
  logic          pop_unused;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [SW-1:0] mem [DEPTH];

  iq_fifo_ctrl #(
    .DEPTH    (DEPTH),
    .AFULL_TH (AFULL_TH),
    .AEMPTY_TH(AEMPTY_TH)
  ) u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .push_in     (push_in),
    .pull_out    (pull_out),
    .clr_err     (clr_err),
    .wr_en       (wr_en),
    .rd_en       (pop_unused),
    .wr_idx      (wr_idx),
    .rd_idx      (rd_idx),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= samp_in;
  end

  // Fall-through head, forced to zero when empty.
  assign samp_out = empty ? '0 : mem[rd_idx];

endmodule

// File: tb/tb_iq_sample_fifo.sv
// Scoreboard bench for iq_sample_fifo at DEPTH=4.
// Directed vectors; monitor checks pop order.
module tb_iq_sample_fifo;

  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_in;
  logic [47:0] samp_in;
  logic        pull_out;
  logic        clr_err;
  logic [47:0] samp_out;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [2:0]  level;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  logic [47:0] expq [$];
  int          mlevel;
  logic        m_ovf;
  logic        m_udf;

  always #5 clk = ~clk;

  iq_sample_fifo #(
    .DATA_W(24),
    .NCH   (2),
    .DEPTH (DEP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push_in     (push_in),
    .samp_in     (samp_in),
    .pull_out    (pull_out),
    .clr_err     (clr_err),
    .samp_out    (samp_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  function automatic logic [47:0] mk(input logic [23:0] i);
    return {i + 24'h000100, i};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Monitor: every accepted pull must pop the
  // oldest expected entry.
  always @(negedge clk) begin
    if (!reset && pull_out && !empty) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_order: got %0h expected none",
                 samp_out);
      end else begin
        chk("pop_order", samp_out, expq.pop_front());
      end
    end
  end

  // One operation held across one active edge;
  // returns at the following negedge.
  task automatic op(input logic p, input logic [47:0] d,
                    input logic q, input logic c);
    logic ap;
    logic aq;
    @(posedge clk);
    #1;
    push_in  = p;
    samp_in  = d;
    pull_out = q;
    clr_err  = c;
    ap = p && (mlevel < DEP || q);
    aq = q && (mlevel > 0);
    if (ap) expq.push_back(d);
    if (p && !ap) m_ovf = 1'b1;
    else if (c)   m_ovf = 1'b0;
    if (q && !aq) m_udf = 1'b1;
    else if (c)   m_udf = 1'b0;
    mlevel = mlevel + int'(ap) - int'(aq);
    @(posedge clk);
    #1;
    push_in  = 1'b0;
    samp_in  = '0;
    pull_out = 1'b0;
    clr_err  = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_model(input string t);
    logic [47:0] hd;
    hd = (mlevel > 0) ? expq[0] : 48'h0;
    chk({t, "_level"}, level, mlevel);
    chk({t, "_full"}, full, mlevel == DEP);
    chk({t, "_empty"}, empty, mlevel == 0);
    chk({t, "_afull"}, almost_full, mlevel >= DEP - 1);
    chk({t, "_aempty"}, almost_empty, mlevel <= 1);
    chk({t, "_ovf"}, overflow, m_ovf);
    chk({t, "_udf"}, underflow, m_udf);
    chk({t, "_head"}, samp_out, hd);
  endtask

  initial begin
    reset    = 1'b1;
    push_in  = 1'b0;
    samp_in  = '0;
    pull_out = 1'b0;
    clr_err  = 1'b0;
    mlevel   = 0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
    #2;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_afull", almost_full, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_samp", samp_out, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      op(1'b1, mk(24'(i)), 1'b0, 1'b0);
      chk("fill_level", level, i);
      chk("fill_afull", almost_full, i >= 3);
      chk("fill_full", full, i == 4);
      chk("fill_ovf", overflow, 0);
    end
    chk("fill_head", samp_out, mk(24'h1));

    op(1'b1, mk(24'hAA), 1'b0, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 4);
    op(1'b1, mk(24'hBB), 1'b0, 1'b1);
    chk("ovf_set_wins", overflow, 1);
    for (int i = 0; i < 4; i++) op(1'b0, '0, 1'b1, 1'b0);
    chk("drain_empty", empty, 1);
    chk("drain_samp", samp_out, 0);
    op(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", overflow, 0);
    chk_model("after_clr");

    op(1'b1, mk(24'h55), 1'b1, 1'b0);
    chk("udf_level", level, 1);
    chk("udf_samp_i", samp_out[23:0], 24'h55);
    chk("udf_samp_q", samp_out[47:24], 24'h155);
    chk("udf_set", underflow, 1);
    op(1'b0, '0, 1'b1, 1'b1);
    chk("udf_clr", underflow, 0);
    chk_model("after_udf");

    for (int i = 1; i <= 4; i++)
      op(1'b1, mk(24'(i)), 1'b0, 1'b0);
    chk("sim_pre_head", samp_out[23:0], 24'h1);
    op(1'b1, mk(24'h9), 1'b1, 1'b0);
    chk("sim_head", samp_out[23:0], 24'h2);
    chk("sim_level", level, 4);
    chk("sim_ovf", overflow, 0);
    chk_model("sim_full");
    for (int i = 0; i < 4; i++) op(1'b0, '0, 1'b1, 1'b0);
    chk_model("sim_drained");

    op(1'b1, mk(24'h10), 1'b0, 1'b0);
    op(1'b1, mk(24'h11), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) op(1'b0, '0, 1'b1, 1'b0);
      else op(1'b1, mk(24'(24'h200 + k)), 1'b0, 1'b0);
      chk("wrap_range", (level >= 1) && (level <= 2), 1);
    end
    chk_model("wrap_end");
    op(1'b0, '0, 1'b1, 1'b0);
    op(1'b0, '0, 1'b1, 1'b0);
    chk("wrap_drained", expq.size(), 0);
    chk_model("wrap_empty");

    for (int i = 1; i <= 4; i++)
      op(1'b1, mk(24'(24'h30 + i)), 1'b0, 1'b0);
    op(1'b1, mk(24'hAA), 1'b0, 1'b0);
    op(1'b0, '0, 1'b1, 1'b0);
    chk("mid_level", level, 3);
    chk("mid_ovf", overflow, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_level", level, 0);
    chk("arst_samp", samp_out, 0);
    chk("arst_ovf", overflow, 0);
    expq.delete();
    mlevel = 0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    op(1'b1, mk(24'h77), 1'b0, 1'b0);
    chk_model("post_rst");
    op(1'b0, '0, 1'b1, 1'b0);
    chk_model("post_rst_empty");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
